// File: rtl/subleq_uart_pkg.sv
// -----------------------------------------------------------------------------
// subleq_uart_pkg
// Shared definitions for the SUBLEQ UART blocks (receiver now, transmitter
// later): byte width, default bit-period divider for 50 MHz / 115200 baud,
// the receiver state encoding, and an even-parity helper.
// -----------------------------------------------------------------------------
package subleq_uart_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEFAULT_DIV = 434;   // 50_000_000 / 115_200, rounded

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [BYTE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Byte handshake and error-pulse bundle between uart_rx and its consumer.
//   rx_data    : byte at FIFO head, meaningful only while rx_valid=1
//   rx_valid   : receive FIFO not empty
//   rx_ready   : consumer takes the head byte on rx_valid & rx_ready
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completed byte dropped (FIFO full)
//   parity_err : one-cycle pulse, parity mismatch (parity builds only)
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
import subleq_uart_pkg::*;

interface uart_rx_if;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
    logic              parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output frame_err,
        output overrun,
        output parity_err
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  frame_err,
        input  overrun,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO with push/pop/full/empty/count, shared by the UART
// receive path and (later) the transmit path.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request and data (ignored while full unless
//                         a pop happens in the same cycle)
//   pop                 : read request (ignored while empty)
//   rd_data             : head entry, mem[rd_ptr]
//   full, empty, count  : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is
    // still accepted in that case.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Serial receiver for the SUBLEQ core's I/O path. Synchronises the raw rx
// line, deframes 8N1 characters (LSB first) by sampling at mid-bit, buffers
// bytes in uart_rx_fifo and offers them over a valid/ready handshake.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   rx     : raw serial line, asynchronous, idles high
//   bus    : uart_rx_if.master (rx_data/rx_valid/rx_ready, error pulses)
// Parameters: DIV clocks per bit (4..65535), FIFO_DEPTH (power of two, 2..16).
// Build option: define UART_RX_PARITY_EN for 8E1 framing with parity_err;
// without it the format is 8N1 and parity_err is constant 0.
// -----------------------------------------------------------------------------
import subleq_uart_pkg::*;

module uart_rx #(
    parameter int DIV        = DEFAULT_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam logic [15:0] HALF_DIV = 16'(DIV / 2);
    localparam logic [15:0] FULL_DIV = 16'(DIV - 1);
    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

    logic              rx_sync_p0;
    logic              rx_sync_p1;
    logic              rxs;

    rx_state_t         state;
    logic [15:0]       baud_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shift;
    logic              expire;

    logic              push_req;
    logic [BYTE_W-1:0] push_byte;
    logic              frame_err_r;
    logic              overrun_r;

    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              pop;

`ifdef UART_RX_PARITY_EN
    logic              par_ok;
    logic              parity_err_r;
`endif

    // Stage p0/p1: two-flop synchroniser, preset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rxs    = rx_sync_p1;
    assign expire = (baud_cnt == '0);

    // Deframing FSM: all decisions on rxs, outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            push_req    <= 1'b0;
            push_byte   <= '0;
            frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok       <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            push_req    <= 1'b0;
            frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        baud_cnt <= HALF_DIV;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (rxs) begin
                            // Low pulse shorter than half a bit: glitch.
                            state <= ST_IDLE;
                        end else begin
                            baud_cnt <= FULL_DIV;
                            bit_cnt  <= '0;
                            state    <= ST_DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shift    <= {rxs, shift[BYTE_W-1:1]};
                        baud_cnt <= FULL_DIV;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (expire) begin
                        par_ok   <= (rxs == even_parity(shift));
                        baud_cnt <= FULL_DIV;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (expire) begin
                        if (rxs) begin
                            state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_ok) begin
                                push_req  <= 1'b1;
                                push_byte <= shift;
                            end else begin
                                parity_err_r <= 1'b1;
                            end
`else
                            push_req  <= 1'b1;
                            push_byte <= shift;
`endif
                        end else begin
                            // Framing error wins over parity; byte dropped.
                            frame_err_r <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line returns high so a stuck-low
                    // line does not retrigger a new frame.
                    if (rxs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pop = bus.rx_ready & ~fifo_empty;

    // Push stage: byte into FIFO, or overrun if no room this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= push_req & fifo_full & ~pop;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_byte),
        .pop       (pop),
        .rd_data   (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rx_data   = fifo_head;
    assign bus.rx_valid  = (fifo_count != '0);
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx (DIV=8, FIFO_DEPTH=4). The sender pushes the
// byte or error event each frame should produce; a monitor pops and compares
// whenever the DUT hands over a byte or pulses an error flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
import subleq_uart_pkg::*;

module tb_uart_rx;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    uart_rx_if bus();

    uart_rx #(
        .DIV        (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];   // bytes the consumer should see, in order
    logic [7:0] err_q[$];   // expected error pulses: "F", "O", "P"

`ifdef UART_RX_PARITY_EN
    bit bad_parity = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    initial begin
        logic [7:0] kind;
        logic [7:0] e;
        int n;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                n = int'(bus.frame_err) + int'(bus.overrun) + int'(bus.parity_err);
                if (n > 1) begin
                    check("err_exclusive", 32'(n), 32'd1);
                end else if (n == 1) begin
                    kind = bus.frame_err ? "F" : (bus.overrun ? "O" : "P");
                    if (err_q.size() == 0) begin
                        check("unexpected_err", 32'(kind), 32'd0);
                    end else begin
                        e = err_q.pop_front();
                        check("err_kind", 32'(kind), 32'(e));
                    end
                end
                if (bus.rx_valid && bus.rx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 32'(bus.rx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 32'(bus.rx_data), 32'(e));
                    end
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (DIV) @(negedge clk);
    endtask

    // Reference model: a frame yields a framing error if its stop bit is 0,
    // otherwise a parity error if the parity is wrong, otherwise an overrun if
    // DEPTH bytes are already waiting, otherwise the byte itself.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        if (!stop_bit) begin
            err_q.push_back("F");
        end
`ifdef UART_RX_PARITY_EN
        else if (bad_parity) begin
            err_q.push_back("P");
        end
`endif
        else if (exp_q.size() >= DEPTH) begin
            err_q.push_back("O");
        end else begin
            exp_q.push_back(d);
        end
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_parity);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic gap(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic drain();
        int k = 0;
        bus.rx_ready = 1'b1;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        #1;
        check("valid_after_drain", 32'(bus.rx_valid), 32'd0);
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("rst_valid",      32'(bus.rx_valid),   32'd0);
        check("rst_data",       32'(bus.rx_data),    32'd0);
        check("rst_frame_err",  32'(bus.frame_err),  32'd0);
        check("rst_overrun",    32'(bus.overrun),    32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        rst_n = 1'b1;
        gap(2 * DIV);

        // Single byte, consumer always ready.
        bus.rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        gap(DIV);
        drain();

        // Three bytes back to back with the consumer stalled.
        bus.rx_ready = 1'b0;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        gap(DIV);
        #1;
        check("stalled_valid", 32'(bus.rx_valid), 32'd1);
        check("stalled_head",  32'(bus.rx_data),  32'h00);
        drain();

        // Five bytes into a four-deep FIFO: the fifth overruns.
        bus.rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
        end
        gap(DIV);
        #1;
        check("full_head", 32'(bus.rx_data), 32'h01);
        drain();

        // Framing error followed by a held-low line, then a good byte.
        bus.rx_ready = 1'b1;
        send_frame(8'h55, 1'b0);
        repeat (3 * DIV) @(negedge clk);
        #1;
        check("break_no_valid", 32'(bus.rx_valid), 32'd0);
        gap(DIV);
        send_frame(8'h12, 1'b1);
        gap(DIV);
        drain();

        // Short low glitch must be ignored.
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        gap(3 * DIV);
        #1;
        check("glitch_no_valid", 32'(bus.rx_valid), 32'd0);

        // Reset mid-frame with a byte already buffered.
        bus.rx_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        gap(DIV);
        rx = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rx_valid), 32'd0);
        check("midrst_data",  32'(bus.rx_data),  32'd0);
        exp_q.delete();
        err_q.delete();
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        gap(2 * DIV);
        bus.rx_ready = 1'b1;
        send_frame(8'h96, 1'b1);
        gap(DIV);
        drain();

`ifdef UART_RX_PARITY_EN
        // Correct parity accepted; flipped parity reported and discarded.
        send_frame(8'h07, 1'b1);
        gap(DIV);
        drain();
        bad_parity = 1'b1;
        send_frame(8'h07, 1'b1);
        bad_parity = 1'b0;
        gap(DIV);
        drain();
`endif

        // Randomized bursts with occasional framing errors.
        for (int r = 0; r < 6; r++) begin
            int burst;
            burst = $urandom_range(1, 6);
            bus.rx_ready = 1'b0;
            for (int b = 0; b < burst; b++) begin
                logic [7:0] d;
                logic       stop;
                d    = 8'($urandom);
                stop = ($urandom_range(0, 7) != 0);
                send_frame(d, stop);
                if (!stop) begin
                    repeat ($urandom_range(DIV, 2 * DIV)) @(negedge clk);
                end
                gap($urandom_range(0, DIV));
            end
            gap(DIV);
            drain();
        end

        gap(2 * DIV);
        check("pending_bytes",  32'(exp_q.size()), 32'd0);
        check("pending_errors", 32'(err_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
